area_ctrl_sched: RTL and testbench

AREA_CTRL_SCHED -- requirements
Module: area_ctrl_sched

---
 rtl/area_ctrl_sched.sv | 146 ++++++++++++++
 tb/tb_area_ctrl_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/area_ctrl_sched.sv
// -----------------------------------------------------------------------------
// area_ctrl_sched
//   Arbitrates four requesters for a shared combinational area-control decoder.
//   The winner's opcode is driven to the decoder for one ISSUE cycle, the result
//   is registered into ctrl_q, and the grant is then held for hold_len+1 HOLD
//   cycles plus one DONE cycle before the block returns to IDLE.
//
//   Build option:
//     AREA_SCHED_RR_EN  defined   -> round-robin arbitration (2-bit rr_ptr)
//                       undefined -> fixed priority, req[0] highest
//
//   Ports:
//     clk       in   1   clock, rising edge
//     rst_n     in   1   asynchronous active-low reset
//     req       in   4   request lines, bit i = requester i
//     op        in  28   opcodes, requester i on op[7i+6:7i]
//     hold_len  in   4   dwell count, HOLD lasts hold_len+1 cycles
//     dec_x     out  7   opcode to the decoder (zero in IDLE/DONE)
//     dec_y     in  26   decoder result for dec_x, same cycle
//     ctrl_q    out 26   registered control word
//     ctrl_vld  out  1   ctrl_q valid (HOLD cycles)
//     gnt       out  4   one-hot grant, zero when idle
//     busy      out  1   high whenever not IDLE
//     done      out  1   one-cycle completion pulse
// -----------------------------------------------------------------------------
module area_ctrl_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [27:0] op,
  input  logic [3:0]  hold_len,
  output logic [6:0]  dec_x,
  input  logic [25:0] dec_y,
  output logic [25:0] ctrl_q,
  output logic        ctrl_vld,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [6:0]  op_l;
  logic [3:0]  cnt;
  logic [6:0]  op_arr [4];
  logic [1:0]  win_idx;

`ifdef AREA_SCHED_RR_EN
  logic [1:0]  rr_ptr;
`endif

  // Split the packed opcode bus into one entry per requester.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      op_arr[k] = op[7*k +: 7];
    end
  end

  // Winner selection. Only meaningful when |req; the FSM ignores it otherwise.
  // NOTE: every variable assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win_idx = 2'd0;
    found   = 1'b0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
`ifdef AREA_SCHED_RR_EN
      // Ascending search starting at rr_ptr; the 2-bit add wraps 3 -> 0.
      idx = rr_ptr + k[1:0];
`else
      idx = k[1:0];
`endif
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_l     <= 7'h00;
      cnt      <= 4'h0;
      dec_x    <= 7'h00;
      ctrl_q   <= 26'h0;
      ctrl_vld <= 1'b0;
      gnt      <= 4'h0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef AREA_SCHED_RR_EN
      rr_ptr   <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            op_l  <= op_arr[win_idx];
            dec_x <= op_arr[win_idx];
            cnt   <= hold_len;
            gnt   <= 4'b0001 << win_idx;
            busy  <= 1'b1;
            state <= ISSUE;
`ifdef AREA_SCHED_RR_EN
            rr_ptr <= win_idx + 2'd1;
`endif
          end
        end
        ISSUE: begin
          // dec_x already carries op_l this cycle, so dec_y is the decode of it.
          ctrl_q   <= dec_y;
          ctrl_vld <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (cnt == 4'h0) begin
            ctrl_vld <= 1'b0;
            done     <= 1'b1;
            dec_x    <= 7'h00;
            state    <= DONE;
          end else begin
            cnt <= cnt - 4'h1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          gnt   <= 4'h0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_area_ctrl_sched.sv
// -----------------------------------------------------------------------------
// tb_area_ctrl_sched
//   Self-checking bench for area_ctrl_sched. A transaction-level model predicts
//   the winner of each arbitration, the decoded control word and the cycle
//   counts of grant, valid and done for every operation. Follows the DUT build:
//   define AREA_SCHED_RR_EN for both to exercise round-robin.
// -----------------------------------------------------------------------------
module tb_area_ctrl_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [27:0] op;
  logic [3:0]  hold_len;
  logic [6:0]  dec_x;
  logic [25:0] dec_y;
  logic [25:0] ctrl_q;
  logic        ctrl_vld;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rr_model = 0;

  area_ctrl_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .op       (op),
    .hold_len (hold_len),
    .dec_x    (dec_x),
    .dec_y    (dec_y),
    .ctrl_q   (ctrl_q),
    .ctrl_vld (ctrl_vld),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared area-control decoder.
  function automatic logic [25:0] dec_fn(input logic [6:0] x);
    return {x, x ^ 7'h55, x + 7'd3, x[4:0] ^ 5'h1b};
  endfunction

  assign dec_y = dec_fn(dec_x);

  // Arbitration model: first set request bit found scanning from the start point.
  function automatic int model_pick(input logic [3:0] r);
    int start;
`ifdef AREA_SCHED_RR_EN
    start = rr_model;
`else
    start = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One complete operation starting from IDLE. Optionally disturbs req, op and
  // hold_len right after the grant. Returns the cycle index of the grant.
  task automatic do_op(input logic [3:0] r, input logic [27:0] o,
                       input logic [3:0] hl, input bit mutate, output int gcyc);
    int         w;
    logic [6:0] eo;
    logic [3:0] eg;
    int         gcnt, vcnt, dcnt, first_vld;
    bit         fin;
    w  = model_pick(r);
    eo = o[7*w +: 7];
    eg = 4'(1 << w);
    req = r; op = o; hold_len = hl;
    step();
    gcyc = cyc;
    total++;
    if (gnt !== eg) begin
      bad++; $display("FAIL grant: gnt=%b expected=%b (req=%b)", gnt, eg, r);
    end
    total++;
    if (dec_x !== eo || busy !== 1'b1 || ctrl_vld !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL issue: dec_x=%h busy=%b vld=%b done=%b expected dec_x=%h busy=1 vld=0 done=0",
                      dec_x, busy, ctrl_vld, done, eo);
    end
    if (mutate) begin
      req = 4'h0; op = 28'($urandom); hold_len = 4'($urandom);
    end
    gcnt = 1; vcnt = 0; dcnt = 0; first_vld = -1; fin = 0;
    for (int i = 1; i <= 40 && !fin; i++) begin
      step();
      if (gnt === eg) gcnt++;
      if (ctrl_vld === 1'b1) begin
        vcnt++;
        if (first_vld < 0) first_vld = i;
        total++;
        if (dec_x !== eo || ctrl_q !== dec_fn(eo) || gnt !== eg || done !== 1'b0) begin
          bad++; $display("FAIL hold: dec_x=%h ctrl_q=%h gnt=%b done=%b expected dec_x=%h ctrl_q=%h gnt=%b done=0",
                          dec_x, ctrl_q, gnt, done, eo, dec_fn(eo), eg);
        end
      end
      if (done === 1'b1) begin
        dcnt++;
        fin = 1;
        total++;
        if (ctrl_vld !== 1'b0 || dec_x !== 7'h00 || gnt !== eg || busy !== 1'b1 || ctrl_q !== dec_fn(eo)) begin
          bad++; $display("FAIL done_cycle: vld=%b dec_x=%h gnt=%b busy=%b ctrl_q=%h expected vld=0 dec_x=00 gnt=%b busy=1 ctrl_q=%h",
                          ctrl_vld, dec_x, gnt, busy, ctrl_q, eg, dec_fn(eo));
        end
      end
    end
    total++;
    if (fin !== 1'b1) begin
      bad++; $display("FAIL timeout: no done within 40 cycles, expected done after %0d", hl + 2);
    end
    total++;
    if (vcnt !== int'(hl) + 1) begin
      bad++; $display("FAIL vld_len: ctrl_vld cycles=%0d expected=%0d", vcnt, int'(hl) + 1);
    end
    total++;
    if (first_vld !== 1) begin
      bad++; $display("FAIL latency: first ctrl_vld %0d cycles after issue, expected 1", first_vld);
    end
    total++;
    if (gcnt !== int'(hl) + 3) begin
      bad++; $display("FAIL gnt_len: gnt cycles=%0d expected=%0d", gcnt, int'(hl) + 3);
    end
    step();
    total++;
    if (gnt !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || ctrl_vld !== 1'b0 ||
        dec_x !== 7'h00 || ctrl_q !== dec_fn(eo)) begin
      bad++; $display("FAIL idle: gnt=%b busy=%b done=%b vld=%b dec_x=%h ctrl_q=%h expected zeros, ctrl_q=%h",
                      gnt, busy, done, ctrl_vld, dec_x, ctrl_q, dec_fn(eo));
    end
    rr_model = (w + 1) % 4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'h0; op = 28'h0; hold_len = 4'h0;
    #2;
    total++;
    if (gnt !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || ctrl_vld !== 1'b0 ||
        dec_x !== 7'h00 || ctrl_q !== 26'h0) begin
      bad++; $display("FAIL reset_state: gnt=%b busy=%b done=%b vld=%b dec_x=%h ctrl_q=%h expected all zero",
                      gnt, busy, done, ctrl_vld, dec_x, ctrl_q);
    end
    step(); step();
    rst_n = 1'b1;
    rr_model = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (gnt !== 4'h0 || busy !== 1'b0) begin
        bad++; $display("FAIL idle_no_req: gnt=%b busy=%b expected 0000/0", gnt, busy);
      end
    end
  endtask

  task automatic test_single();
    logic [27:0] o;
    int g;
    o = 28'($urandom);
    o[20:14] = 7'h2A;
    do_op(4'b0100, o, 4'd2, 1'b0, g);
  endtask

  task automatic test_back_to_back(input logic [3:0] r);
    int g, prev;
    prev = -1;
    for (int n = 0; n < 5; n++) begin
      do_op(r, 28'($urandom), 4'd0, 1'b0, g);
      if (prev >= 0) begin
        total++;
        if (g - prev !== 4) begin
          bad++; $display("FAIL spacing: grants %0d cycles apart, expected 4 (req=%b)", g - prev, r);
        end
      end
      prev = g;
    end
    req = 4'h0;
    step();
  endtask

  task automatic test_withdraw();
    int g;
    do_op(4'b1000, 28'($urandom), 4'd3, 1'b1, g);
  endtask

  task automatic test_long_hold();
    int g;
    do_op(4'b0001, 28'($urandom), 4'd15, 1'b1, g);
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 10; n++) begin
      do_op(4'($urandom_range(1, 15)), 28'($urandom), 4'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), g);
      req = 4'h0;
    end
  endtask

  task automatic test_reset_mid();
    int  w;
    bit  saw_done;
    bit  fin;
    saw_done = 0;
    req = 4'b0110; op = 28'($urandom); hold_len = 4'd15;
    step();                                  // grant
    for (int i = 0; i < 5; i++) begin
      step();
      if (done === 1'b1) saw_done = 1;
    end
    total++;
    if (ctrl_vld !== 1'b1) begin
      bad++; $display("FAIL pre_reset: ctrl_vld=%b expected 1 (in HOLD)", ctrl_vld);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || ctrl_vld !== 1'b0 ||
        dec_x !== 7'h00 || ctrl_q !== 26'h0) begin
      bad++; $display("FAIL async_reset: gnt=%b busy=%b done=%b vld=%b dec_x=%h ctrl_q=%h expected all zero",
                      gnt, busy, done, ctrl_vld, dec_x, ctrl_q);
    end
    step();
    if (done === 1'b1) saw_done = 1;
    step();
    if (done === 1'b1) saw_done = 1;
    rst_n = 1'b1;
    rr_model = 0;
    w = model_pick(req);
    step();                                  // first edge after release
    total++;
    if (gnt !== 4'(1 << w) || busy !== 1'b1) begin
      bad++; $display("FAIL regrant: gnt=%b busy=%b expected gnt=%b busy=1", gnt, busy, 4'(1 << w));
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++; $display("FAIL abort_done: done pulse seen=%b expected 0", saw_done);
    end
    req = 4'h0;
    fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      step();
      if (done === 1'b1) fin = 1;
    end
    total++;
    if (fin !== 1'b1) begin
      bad++; $display("FAIL regrant_timeout: no done within 40 cycles after regrant");
    end
    step();
    rr_model = (w + 1) % 4;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back(4'b1111);
    test_back_to_back(4'b1010);
    test_withdraw();
    test_long_hold();
    test_random();
    test_reset_mid();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
